uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources,
// holding the grant across multi-byte messages and dropping stale locks after a timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           owner,
  output logic                 locked
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam int              CNT_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);

  logic [1:0]         state;
  logic               last_q;
  logic [CNT_W-1:0]   idle_cnt;
  logic [NUM_REQ-1:0] eligible;
  logic               owner_req;
  logic               win_found;
  logic [2:0]         win_idx;
  logic [7:0]         win_data;
  logic               win_last;
  int                 rr_dist;
  int                 rr_best;

  // Winner is the eligible requester with the smallest upward distance from owner+1.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    eligible  = '0;
    owner_req = 1'b0;
    win_idx   = owner;
    win_data  = 8'h00;
    win_last  = 1'b0;
    rr_dist   = 0;
    rr_best   = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] && (!locked || owner == 3'(i));
      if (owner == 3'(i)) owner_req = req[i];
      if (eligible[i]) begin
        rr_dist = (i + 2 * NUM_REQ - int'(owner) - 1) % NUM_REQ;
        if (rr_dist < rr_best) begin
          rr_best  = rr_dist;
          win_idx  = 3'(i);
          win_data = req_data[8*i +: 8];
          win_last = req_last[i];
        end
      end
    end
    win_found = |eligible;
  end

  // NOTE: tx_send and ack decode the state directly, so an async reset drops them at once.
  always_comb begin
    ack     = '0;
    tx_send = (state == SEND);
    for (int i = 0; i < NUM_REQ; i++) ack[i] = (state == SEND) && (owner == 3'(i));
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      owner    <= 3'(NUM_REQ - 1);
      locked   <= 1'b0;
      last_q   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      idle_cnt <= '0;
      case (state)
        IDLE: begin
          if (locked && !owner_req) begin
            if (idle_cnt == CNT_MAX) locked <= 1'b0;
            else                     idle_cnt <= idle_cnt + CNT_W'(1);
          end
          if (!tx_busy && win_found) begin
            state   <= SEND;
            owner   <= win_idx;
            tx_data <= win_data;
            last_q  <= win_last;
          end
        end
        SEND:      state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!tx_busy) begin
            state  <= IDLE;
            locked <= !last_q;
          end
        end
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run,
// all compared every cycle against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int LT = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [2:0]     owner;
  logic           locked;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy),
    .owner(owner), .locked(locked)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per-requester message scripts: {last, data}; the head byte is presented until acked.
  bit [8:0]  msgq [N][$];
  int        sent_owner[$];
  bit [7:0]  sent_data[$];
  int        sent_cyc[$];
  bit        sent_locked[$];

  int busy_left, busy_dur, lock_obs;
  bit busy_pend, force_busy, random_on;

  // Reference model: which requester holds the link, whether a message is open,
  // and where the current byte is in its send / transmitter-busy life cycle.
  int       m_owner, m_idle_cnt;
  bit       m_locked, m_last, m_send_now, m_in_flight, m_busy_seen;
  bit [7:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = N - 1; m_idle_cnt = 0; m_locked = 0; m_last = 0;
    m_send_now = 0; m_in_flight = 0; m_busy_seen = 0; m_data = 8'h00;
  endtask

  task automatic model_step();
    int win;
    if (m_send_now) begin
      m_send_now = 0; m_in_flight = 1; m_busy_seen = 0;
    end else if (m_in_flight) begin
      if (!m_busy_seen) begin
        if (tx_busy) m_busy_seen = 1;
      end else if (!tx_busy) begin
        m_in_flight = 0;
        m_locked    = !m_last;
      end
    end else begin
      win = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_owner + k) % N;
        if (win < 0 && req[idx] && (!m_locked || idx == m_owner)) win = idx;
      end
      if (m_locked && !req[m_owner]) begin
        m_idle_cnt++;
        if (m_idle_cnt == LT) begin m_locked = 0; m_idle_cnt = 0; end
      end else m_idle_cnt = 0;
      if (!tx_busy && win >= 0) begin
        m_owner = win; m_data = req_data[8*win +: 8]; m_last = req_last[win]; m_send_now = 1;
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] ea;
    ea = m_send_now ? (N'(1) << m_owner) : '0;
    check("tx_send", tx_send, m_send_now);
    check("ack", ack, ea);
    check("owner", owner, m_owner);
    check("locked", locked, m_locked);
    check("tx_data", tx_data, m_data);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (msgq[i].size() > 0) begin
        req[i] = 1'b1; req_data[8*i +: 8] = msgq[i][0][7:0]; req_last[i] = msgq[i][0][8];
      end else begin
        req[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic rand_stim();
    int nb;
    bit stale;
    if ($urandom_range(0, 15) == 0) force_busy = !force_busy;
    if (tx_send) busy_dur = $urandom_range(1, 5);
    for (int i = 0; i < N; i++) begin
      if (msgq[i].size() == 0 && $urandom_range(0, 5) == 0) begin
        nb    = $urandom_range(1, 3);
        stale = ($urandom_range(0, 4) == 0);
        for (int b = 0; b < nb; b++) msgq[i].push_back({(b == nb - 1) && !stale, 8'($urandom)});
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    cyc++;
    compare();
    if (tx_send) begin
      sent_owner.push_back(int'(owner)); sent_data.push_back(tx_data);
      sent_cyc.push_back(cyc); sent_locked.push_back(locked);
    end
    if (locked) lock_obs++;
    for (int i = 0; i < N; i++) if (ack[i] && msgq[i].size() > 0) msgq[i].delete(0);
    if (random_on) rand_stim();
    if (busy_left > 0) busy_left--;
    if (busy_pend) begin busy_left = busy_dur; busy_pend = 0; end
    if (tx_send) busy_pend = 1;
    tx_busy = (busy_left > 0) || force_busy;
    drive_reqs();
  endtask

  task automatic clear_bench();
    for (int i = 0; i < N; i++) msgq[i].delete();
    sent_owner.delete(); sent_data.delete(); sent_cyc.delete(); sent_locked.delete();
    force_busy = 0; busy_left = 0; busy_pend = 0; busy_dur = 3; random_on = 0; lock_obs = 0;
    tx_busy = 1'b0;
    model_reset();
    drive_reqs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_bench();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare();
  endtask

  // Asserts reset mid-cycle and expects every output at its reset value before the next edge.
  task automatic mid_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    check({tag, "_tx_send"}, tx_send, 0);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_owner"}, owner, N - 1);
    check({tag, "_locked"}, locked, 0);
    clear_bench();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  function automatic int nth_owner(input int k);
    return (sent_owner.size() > k) ? sent_owner[k] : -1;
  endfunction

  function automatic int nth_data(input int k);
    return (sent_data.size() > k) ? int'(sent_data[k]) : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drained;

    // Reset values and a single byte from requester 2.
    do_reset();
    check("rst_tx_send", tx_send, 0);
    check("rst_ack", ack, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_owner", owner, 3);
    check("rst_locked", locked, 0);
    msgq[2].push_back({1'b1, 8'h48});
    drive_reqs();
    tick();
    check("single_tx_send", tx_send, 1);
    check("single_tx_data", tx_data, 8'h48);
    check("single_ack", ack, 4'b0100);
    check("single_owner", owner, 2);
    repeat (10) tick();
    check("single_locked", locked, 0);
    check("single_count", sent_owner.size(), 1);

    // Contention among 0, 1 and 3 straight after reset.
    do_reset();
    msgq[0].push_back({1'b1, 8'h10});
    msgq[1].push_back({1'b1, 8'h11});
    msgq[3].push_back({1'b1, 8'h13});
    drive_reqs();
    repeat (60) tick();
    check("rr_count", sent_owner.size(), 3);
    check("rr_first", nth_owner(0), 0);
    check("rr_second", nth_owner(1), 1);
    check("rr_third", nth_owner(2), 3);

    // Locked three-byte message from requester 1 while requester 0 waits.
    do_reset();
    msgq[1].push_back({1'b0, 8'h41});
    msgq[1].push_back({1'b0, 8'h42});
    msgq[1].push_back({1'b1, 8'h43});
    drive_reqs();
    tick();
    msgq[0].push_back({1'b1, 8'hA0});
    drive_reqs();
    repeat (60) tick();
    check("lock_b0", nth_data(0), 8'h41);
    check("lock_b1", nth_data(1), 8'h42);
    check("lock_b2", nth_data(2), 8'h43);
    check("lock_b3", nth_data(3), 8'hA0);
    check("lock_b3_owner", nth_owner(3), 0);
    check("lock_held", (sent_locked.size() > 2) ? {sent_locked[1], sent_locked[2]} : 2'b00, 2'b11);
    check("lock_released", (sent_locked.size() > 3) ? sent_locked[3] : 1'b1, 0);

    // Stale lock: requester 3 leaves a message open, requester 1 is served after the timeout.
    do_reset();
    msgq[3].push_back({1'b0, 8'h33});
    drive_reqs();
    tick();
    msgq[1].push_back({1'b1, 8'h11});
    drive_reqs();
    lock_obs = 0;
    repeat (40) tick();
    check("to_first", nth_owner(0), 3);
    check("to_second", nth_owner(1), 1);
    check("to_gap", (sent_cyc.size() > 1) ? sent_cyc[1] - sent_cyc[0] : -1, 22);
    check("to_locked_cycles", lock_obs, LT);
    check("to_final_locked", locked, 0);

    // Reset during SEND, then during WAIT_DONE, then requester 0 goes first.
    do_reset();
    msgq[2].push_back({1'b0, 8'h55});
    drive_reqs();
    tick();
    check("rsend_pre_tx_send", tx_send, 1);
    mid_reset("rsend");
    msgq[2].push_back({1'b0, 8'h55});
    drive_reqs();
    repeat (3) tick();
    mid_reset("rdone");
    msgq[2].push_back({1'b1, 8'h02});
    msgq[0].push_back({1'b1, 8'h01});
    drive_reqs();
    repeat (20) tick();
    check("rdone_first_owner", nth_owner(0), 0);
    check("rdone_first_data", nth_data(0), 8'h01);

    // Transmitter already busy when a request arrives.
    do_reset();
    force_busy = 1; tx_busy = 1'b1;
    msgq[0].push_back({1'b1, 8'h77});
    drive_reqs();
    repeat (6) tick();
    check("busy_hold", sent_owner.size(), 0);
    force_busy = 0; tx_busy = 1'b0;
    tick();
    check("busy_release_send", tx_send, 1);
    check("busy_release_data", tx_data, 8'h77);

    // Randomized traffic with open messages and spurious busy periods.
    do_reset();
    random_on = 1;
    repeat (4000) tick();
    random_on = 0;
    force_busy = 0;
    tx_busy = (busy_left > 0);
    drained = 0;
    for (int t = 0; t < 600 && !drained; t++) begin
      tick();
      drained = 1;
      for (int i = 0; i < N; i++) if (msgq[i].size() > 0) drained = 0;
      if (m_send_now || m_in_flight) drained = 0;
    end
    check("rand_drained", drained, 1);
    check("rand_activity", sent_owner.size() > 50, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
